ddr3_ps_ctrl: RTL and testbench
===============================

Name: ddr3_ps_ctrl

Overview:
Fine-phase-shift controller for the DDR3 clocking MMCM. It is the initiator side of the MMCM PSEN/PSINCDEC/PSDONE handshake. It takes signed step requests from read-leveling/calibration logic and issues one PSEN pulse per step. It waits for PSDONE after each pulse and tracks the accumulated tap position, with saturation and timeout protection. It runs in the clk_app domain, which is the domain that clocks the MMCM PSCLK.

Parameters:
STEP_W, 8, width of the request step magnitude.
POS_W, 10, width of the signed (two's complement) tap position counter.
POS_MAX, 167, upper position limit (inclusive). One full CLKOUT2 rotation is 168 taps.
POS_MIN, -168, lower position limit (inclusive).
TIMEOUT, 63, clk_app cycles to wait for PSDONE after a PSEN pulse before declaring failure.

Ports:
clk_app  in  1  PSCLK/logic clock.
sys_rst_n  in  1  asynchronous active-low reset.
mmcm_rst  in  1  synchronous active-high. High while the MMCM is in reset or unlocked (driven from rstdiv0).
req_valid  in  1  step request valid.
req_ready  out  1  controller can accept a request.
req_dir  in  1  1 = increment (PSINCDEC=1), 0 = decrement.
req_steps  in  STEP_W  number of steps to apply (unsigned).
PSEN  out  1  to MMCM. One-cycle pulse per step.
PSINCDEC  out  1  to MMCM.
PSDONE  in  1  from MMCM.
done  out  1  one-cycle pulse at request completion.
done_clip  out  1  valid with done. Request was cut short by a position limit.
done_tmo  out  1  valid with done. Request aborted by PSDONE timeout.
steps_done  out  STEP_W  valid with done. Steps actually applied.
phase_pos  out  POS_W  signed current tap position.
busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (sys_rst_n low, async) sets: state IDLE, PSEN=0, PSINCDEC=0, done/done_clip/done_tmo=0, steps_done=0, phase_pos=0, busy=0, req_ready=0.
- req_ready = (state==IDLE) & ~mmcm_rst, registered.
- States: IDLE, CHECK, PULSE, WAIT, FINISH.
- IDLE:
  - Handshake is req_valid & req_ready in cycle T.
  - Latch dir and remaining=req_steps, clear step count and flags, go to CHECK at T+1.
- CHECK:
  - If remaining==0, go to FINISH.
  - Else if (dir & phase_pos==POS_MAX) or (~dir & phase_pos==POS_MIN): set clip, go to FINISH.
  - Else go to PULSE.
- PULSE: PSEN=1 for exactly one cycle with PSINCDEC=dir. Clear the timer. Go to WAIT.
- WAIT:
  - PSINCDEC is held at dir.
  - The timer increments each cycle.
  - PSDONE=1: phase_pos ±1, remaining-1, steps_done+1 (registered next cycle), go to CHECK.
  - Timer==TIMEOUT with no PSDONE: set tmo, go to FINISH. phase_pos is not changed.
- FINISH:
  - done=1 for one cycle, with done_clip, done_tmo and steps_done stable.
  - Go to IDLE. req_ready rises the following cycle.
  - A request cannot be accepted in the same cycle as done.
- PSDONE received in IDLE, CHECK, PULSE or FINISH is ignored and does not update phase_pos.
- Minimum spacing between PSEN pulses is 3 cycles (PULSE, WAIT, CHECK). PSEN is never reasserted before PSDONE or timeout.
- mmcm_rst=1, from any state and with priority over everything else:
  - Next cycle: state IDLE, PSEN=0, phase_pos=0, busy=0, req_ready=0.
  - The in-flight request is dropped with no done pulse.
  - The MMCM phase is lost on its reset, so the position restarts at 0.
- phase_pos arithmetic is POS_W signed. POS_MIN ≤ phase_pos ≤ POS_MAX always holds, so no wrap.
- busy=1 in CHECK, PULSE, WAIT, FINISH.

Test Plan:
- Reset and quiescence: hold sys_rst_n low, then release with mmcm_rst=0 → all outputs 0, req_ready=1 one cycle after release. Spurious PSDONE in IDLE → phase_pos stays 0.
- Increment run: model MMCM returns PSDONE 12 cycles after each PSEN; request dir=1, steps=5 → exactly 5 single-cycle PSEN pulses, PSINCDEC=1 throughout, phase_pos=5, then done=1 with steps_done=5, clip=0, tmo=0. Then dir=0, steps=3 → phase_pos=2.
- Zero-step and back-to-back: steps=0 → done two cycles after the handshake, steps_done=0, no PSEN. A request held valid through done is accepted only once req_ready returns.
- Saturation: POS_MAX=4, phase_pos=2, request dir=1, steps=10 → 2 pulses, phase_pos=4, done with done_clip=1, steps_done=2.
- Timeout: model drops PSDONE on the 3rd pulse of a 5-step request → done_tmo=1 at TIMEOUT+1 cycles after that PSEN, steps_done=2, phase_pos=2. The next request works normally.
- MMCM reset mid-run: assert mmcm_rst during WAIT of step 3 of 6 → PSEN stays 0, no done, phase_pos=0, req_ready=0 until mmcm_rst falls, then 1 the cycle after.

Source files
------------

// File: rtl/ddr3_ps_ctrl.sv
// ddr3_ps_ctrl: initiator side of the MMCM dynamic phase-shift handshake.
// Turns signed step requests into one PSEN pulse per step, waits for PSDONE,
// and keeps a saturating tap position. Runs on clk_app, which also clocks PSCLK.
module ddr3_ps_ctrl #(
    parameter int STEP_W  = 8,
    parameter int POS_W   = 10,
    parameter int POS_MAX = 167,
    parameter int POS_MIN = -168,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_app,
    input  logic              sys_rst_n,
    input  logic              mmcm_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              PSEN,
    output logic              PSINCDEC,
    input  logic              PSDONE,
    output logic              done,
    output logic              done_clip,
    output logic              done_tmo,
    output logic [STEP_W-1:0] steps_done,
    output logic [POS_W-1:0]  phase_pos,
    output logic              busy
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PULSE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            state_q;
    logic              dir_q;
    logic [STEP_W-1:0] remaining_q;
    logic [STEP_W-1:0] steps_q;
    logic              clip_q;
    logic              tmo_q;
    logic              done_q;
    logic              psen_q;
    logic              psincdec_q;
    logic              busy_q;
    logic              ready_q;
    logic [POS_W-1:0]  pos_q;
    logic [TW-1:0]     timer_q;

    logic [POS_W-1:0]  pos_d;
    logic [TW-1:0]     timer_d;
    logic              at_limit;

    // Next tap position for the current direction, timer increment, and limit detection.
    always_comb begin
        pos_d    = dir_q ? (pos_q + 1'b1) : (pos_q - 1'b1);
        timer_d  = timer_q + 1'b1;
        at_limit = dir_q ? (pos_q == POS_W'(POS_MAX)) : (pos_q == POS_W'(POS_MIN));
    end

    // Main handshake FSM; every output is a register, and mmcm_rst overrides all states.
    always_ff @(posedge clk_app or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            steps_q     <= '0;
            clip_q      <= 1'b0;
            tmo_q       <= 1'b0;
            done_q      <= 1'b0;
            psen_q      <= 1'b0;
            psincdec_q  <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            pos_q       <= '0;
            timer_q     <= '0;
        end else if (mmcm_rst) begin
            state_q    <= S_IDLE;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            pos_q      <= '0;
        end else begin
            psen_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        dir_q       <= req_dir;
                        remaining_q <= req_steps;
                        steps_q     <= '0;
                        clip_q      <= 1'b0;
                        tmo_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b0;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (at_limit) begin
                        clip_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        psen_q     <= 1'b1;
                        psincdec_q <= dir_q;
                        state_q    <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_d;
                    if (PSDONE) begin
                        pos_q       <= pos_d;
                        remaining_q <= remaining_q - 1'b1;
                        steps_q     <= steps_q + 1'b1;
                        state_q     <= S_CHECK;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign PSEN       = psen_q;
    assign PSINCDEC   = psincdec_q;
    assign done       = done_q;
    assign done_clip  = clip_q;
    assign done_tmo   = tmo_q;
    assign steps_done = steps_q;
    assign phase_pos  = pos_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ddr3_ps_ctrl.sv
// tb_ddr3_ps_ctrl: directed bench with an MMCM phase-shift responder and a
// completion scoreboard. Limits are narrowed so saturation is reached quickly.
module tb_ddr3_ps_ctrl;

    localparam int STEP_W  = 8;
    localparam int POS_W   = 10;
    localparam int POS_MAX = 7;
    localparam int POS_MIN = -8;
    localparam int TIMEOUT = 63;
    localparam int PS_LAT  = 12;

    logic              clk_app;
    logic              sys_rst_n;
    logic              mmcm_rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;
    logic              PSEN;
    logic              PSINCDEC;
    logic              PSDONE;
    logic              done;
    logic              done_clip;
    logic              done_tmo;
    logic [STEP_W-1:0] steps_done;
    logic [POS_W-1:0]  phase_pos;
    logic              busy;

    logic modelDone;
    logic spuriousDone;
    assign PSDONE = modelDone | spuriousDone;

    typedef struct {
        int   steps;
        logic clip;
        logic tmo;
        int   pos;
    } expect_t;

    expect_t sb[$];

    int   compared      = 0;
    int   mismatched    = 0;
    int   cycleCnt      = 0;
    int   modelPos      = 0;
    int   reqId         = 0;
    int   dropNth       = 0;
    logic expDir        = 1'b0;
    int   expPulses     = 0;
    int   psenStart     = 0;
    int   psenTotal     = 0;
    int   monReqId      = 0;
    int   reqPulse      = 0;
    int   psDelay       = 0;
    int   lastPsenCycle = 0;
    int   doneCount     = 0;
    logic prevPsen      = 1'b0;

    ddr3_ps_ctrl #(
        .STEP_W (STEP_W),
        .POS_W  (POS_W),
        .POS_MAX(POS_MAX),
        .POS_MIN(POS_MIN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_app   (clk_app),
        .sys_rst_n (sys_rst_n),
        .mmcm_rst  (mmcm_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .req_steps (req_steps),
        .PSEN      (PSEN),
        .PSINCDEC  (PSINCDEC),
        .PSDONE    (PSDONE),
        .done      (done),
        .done_clip (done_clip),
        .done_tmo  (done_tmo),
        .steps_done(steps_done),
        .phase_pos (phase_pos),
        .busy      (busy)
    );

    initial clk_app = 1'b0;
    always #5 clk_app = ~clk_app;

    // Free-running cycle counter used to time the timeout completion.
    always @(posedge clk_app) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // MMCM responder plus PSEN protocol checks and completion scoreboard.
    always @(negedge clk_app) begin : monitor
        expect_t e;
        modelDone = 1'b0;
        if (psDelay > 0) begin
            psDelay--;
            if (psDelay == 0) modelDone = 1'b1;
        end
        if (monReqId != reqId) begin
            monReqId = reqId;
            reqPulse = 0;
        end
        if (PSEN === 1'b1) begin
            psenTotal++;
            reqPulse++;
            lastPsenCycle = cycleCnt;
            checkOutput("psincdec_dir", PSINCDEC, expDir);
            checkOutput("psen_single_cycle", prevPsen, 0);
            checkOutput("psen_while_pending", psDelay > 0, 0);
            if (reqPulse != dropNth) psDelay = PS_LAT;
        end
        prevPsen = PSEN;
        if (done === 1'b1) begin
            doneCount++;
            checkOutput("ready_during_done", req_ready, 0);
            checkOutput("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("steps_done", steps_done, e.steps);
                checkOutput("done_clip", done_clip, e.clip);
                checkOutput("done_tmo", done_tmo, e.tmo);
                checkOutput("phase_pos_at_done", $signed(phase_pos), e.pos);
                if (e.tmo) checkOutput("tmo_latency", cycleCnt - lastPsenCycle, TIMEOUT + 1);
            end
        end
    end

    // Compute the expected outcome, queue it, and perform one handshake.
    task automatic applyStimulus(input logic dir, input int steps, input int drop, input bit track);
        int      n   = 0;
        logic    clp = 1'b0;
        logic    tmo = 1'b0;
        int      pos = modelPos;
        int      w   = 0;
        expect_t e;
        while (n < steps) begin
            if (dir ? (pos == POS_MAX) : (pos == POS_MIN)) begin
                clp = 1'b1;
                break;
            end
            if (n + 1 == drop) begin
                tmo = 1'b1;
                break;
            end
            pos = dir ? pos + 1 : pos - 1;
            n++;
        end
        reqId++;
        dropNth   = drop;
        expDir    = dir;
        expPulses = n + (tmo ? 1 : 0);
        if (track) begin
            e.steps = n;
            e.clip  = clp;
            e.tmo   = tmo;
            e.pos   = pos;
            sb.push_back(e);
            modelPos = pos;
        end
        while (req_ready !== 1'b1 && w < 200) begin
            @(negedge clk_app);
            w++;
        end
        checkOutput("ready_before_req", req_ready, 1);
        psenStart = psenTotal;
        req_valid = 1'b1;
        req_dir   = dir;
        req_steps = STEP_W'(steps);
        @(posedge clk_app);
        @(negedge clk_app);
        req_valid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int c = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && c < budget) begin
            @(negedge clk_app);
            c++;
        end
        checkOutput({tag, "_in_budget"}, c < budget, 1);
        checkOutput({tag, "_psen_count"}, psenTotal - psenStart, expPulses);
        checkOutput({tag, "_phase_pos"}, $signed(phase_pos), modelPos);
    endtask

    initial begin : stimulus
        int      c;
        int      doneBase;
        expect_t e;
        sys_rst_n    = 1'b0;
        mmcm_rst     = 1'b0;
        req_valid    = 1'b0;
        req_dir      = 1'b0;
        req_steps    = '0;
        spuriousDone = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_app);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_psen", PSEN, 0);
        checkOutput("rst_psincdec", PSINCDEC, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_done_clip", done_clip, 0);
        checkOutput("rst_done_tmo", done_tmo, 0);
        checkOutput("rst_steps_done", steps_done, 0);
        checkOutput("rst_phase_pos", $signed(phase_pos), 0);
        checkOutput("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        @(negedge clk_app);
        checkOutput("ready_after_release", req_ready, 1);
        checkOutput("busy_after_release", busy, 0);

        // PSDONE while idle must not move the position
        spuriousDone = 1'b1;
        @(negedge clk_app);
        spuriousDone = 1'b0;
        @(negedge clk_app);
        checkOutput("spurious_phase_pos", $signed(phase_pos), 0);
        checkOutput("spurious_busy", busy, 0);

        $display("[TB] increment 5, decrement 3");
        applyStimulus(1'b1, 5, 0, 1'b1);
        waitIdle("inc5", 400);
        applyStimulus(1'b0, 3, 0, 1'b1);
        waitIdle("dec3", 400);

        $display("[TB] zero-step request");
        applyStimulus(1'b1, 0, 0, 1'b1);
        checkOutput("zero_done_early", done, 0);
        @(negedge clk_app);
        checkOutput("zero_done_two_after", done, 1);
        waitIdle("zero", 50);

        $display("[TB] back-to-back zero-step requests with valid held");
        reqId++;
        expPulses = 0;
        e.steps = 0;
        e.clip  = 1'b0;
        e.tmo   = 1'b0;
        e.pos   = modelPos;
        sb.push_back(e);
        sb.push_back(e);
        doneBase  = doneCount;
        psenStart = psenTotal;
        req_steps = '0;
        req_valid = 1'b1;
        c = 0;
        while (done !== 1'b1 && c < 50) begin
            @(negedge clk_app);
            c++;
        end
        checkOutput("b2b_first_done_seen", done, 1);
        c = 0;
        while (req_ready !== 1'b1 && c < 50) begin
            @(negedge clk_app);
            c++;
        end
        checkOutput("b2b_ready_returns", req_ready, 1);
        @(posedge clk_app);
        @(negedge clk_app);
        req_valid = 1'b0;
        waitIdle("b2b", 50);
        repeat (5) @(negedge clk_app);
        checkOutput("b2b_done_count", doneCount - doneBase, 2);

        $display("[TB] saturation at both limits");
        applyStimulus(1'b1, 10, 0, 1'b1);
        waitIdle("clip_max", 600);
        applyStimulus(1'b0, 20, 0, 1'b1);
        waitIdle("clip_min", 900);

        $display("[TB] PSDONE timeout on third pulse");
        applyStimulus(1'b1, 5, 3, 1'b1);
        waitIdle("tmo", 400);
        applyStimulus(1'b1, 2, 0, 1'b1);
        waitIdle("after_tmo", 200);

        $display("[TB] MMCM reset mid-run");
        doneBase = doneCount;
        applyStimulus(1'b1, 6, 0, 1'b0);
        c = 0;
        while (psenTotal - psenStart < 3 && c < 300) begin
            @(negedge clk_app);
            c++;
        end
        checkOutput("mrst_third_pulse_seen", psenTotal - psenStart, 3);
        repeat (2) @(negedge clk_app);
        mmcm_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_app);
            checkOutput("mrst_psen", PSEN, 0);
            checkOutput("mrst_busy", busy, 0);
            checkOutput("mrst_ready", req_ready, 0);
            checkOutput("mrst_phase_pos", $signed(phase_pos), 0);
        end
        mmcm_rst = 1'b0;
        @(negedge clk_app);
        checkOutput("mrst_ready_returns", req_ready, 1);
        repeat (15) @(negedge clk_app);
        modelPos = 0;
        checkOutput("mrst_late_psdone_ignored", $signed(phase_pos), 0);
        checkOutput("mrst_psen_count", psenTotal - psenStart, 3);
        checkOutput("mrst_no_done", doneCount - doneBase, 0);

        applyStimulus(1'b1, 1, 0, 1'b1);
        waitIdle("after_mrst", 100);

        repeat (3) @(negedge clk_app);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
